mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
MEM/WB pipeline stage of the 5-stage RISC-V core. It latches the EX/MEM result together with the raw data-memory word, and performs RV32I load extraction and sign/zero extension. It then drives the register-file write port (WriteAddr/WriteData/RegWrite) consumed by the bypassing register file in ID. It also flags misaligned loads and keeps a retired-instruction counter.

Parameters:
CNT_WIDTH, 32, width of instRetired counter (wraps modulo 2^CNT_WIDTH)
MISALIGN_TRAP, 1, 1 = misaligned load suppresses write and raises loadMisalign; 0 = offset low bits forced to natural alignment and write proceeds

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
stall  input  1  hold all stage state this cycle
flush  input  1  kill incoming instruction (insert bubble)
exValid  input  1  EX/MEM slot holds a real instruction
exRegWrite  input  1  instruction writes rd
exMemToReg  input  1  1 = load (data from memory), 0 = ALU result
exRdAddr  input  5  destination register
exFunct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
exAluResult  input  32  ALU result / load effective address
memReadData  input  32  aligned little-endian word at exAluResult[31:2], valid same cycle
WriteAddr  output  5  register-file write address
WriteData  output  32  register-file write data
RegWrite  output  1  register-file write enable
wbValid  output  1  stage holds a retiring instruction
loadMisalign  output  1  registered one-cycle flag for a misaligned load
instRetired  output  CNT_WIDTH  count of retired instructions

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). All outputs are registered; latency from EX/MEM inputs to outputs is 1 cycle.
- Reset: on a rising edge with rst=1, WriteAddr=0, WriteData=0, RegWrite=0, wbValid=0, loadMisalign=0, instRetired=0. rst overrides flush and stall. Reset mid-stream discards the held instruction with no write.
- Priority per edge: rst > flush > stall > capture.
- flush: wbValid=0, RegWrite=0, loadMisalign=0, WriteAddr=0, WriteData=0. The counter holds.
- stall: all registers hold, including RegWrite. The register file may therefore rewrite the same value; this is legal and idempotent.
- Capture (rst=flush=stall=0):
  - off = exAluResult[1:0].
  - Misaligned (mis) when exMemToReg & exValid and either (funct3[1:0]=01 and off[0]=1) or (funct3[1:0]=10 and off!=0). Byte loads are never misaligned.
  - When MISALIGN_TRAP=0: mis is forced to 0, and off is replaced by {off[1],1'b0} for halfword loads and by 00 for word loads.
  - Load data: byte = memReadData[8*off+7 : 8*off]; half = memReadData[16*off[1]+15 : 16*off[1]]. LB/LH sign-extend, LBU/LHU zero-extend, LW = full word.
  - Undefined funct3 (011, 110, 111) with exMemToReg=1 is treated as LW.
  - WriteData = exMemToReg ? loadData : exAluResult.
  - WriteAddr = exRdAddr.
  - RegWrite = exValid & exRegWrite & (exRdAddr!=0) & ~mis. Writes to x0 are always suppressed.
  - wbValid = exValid & ~mis.
  - loadMisalign = mis (MISALIGN_TRAP=1 only).
- instRetired: increments by 1 on each edge where the capture path runs with exValid=1 and mis=0. The increment happens whether or not rd=x0 and whether or not exRegWrite is set (stores and branches also retire). It wraps from all-ones to 0 without a flag.
- loadMisalign is high for exactly one cycle per offending instruction unless stall holds it. Under stall it stays high for the duration of the stall.
- exValid=0: the stage captures a bubble, with RegWrite=0, wbValid=0, and no count.

Test Plan:
- Reset: drive rst=1 for 2 cycles with exValid=1, exRegWrite=1, rd=5 -> all outputs 0, instRetired=0. Release rst -> the next edge writes rd=5.
- ALU writeback: exAluResult=0xDEADBEEF, rd=7, exMemToReg=0 -> next cycle WriteAddr=7, WriteData=0xDEADBEEF, RegWrite=1, instRetired=1. Same with rd=0 -> RegWrite=0, instRetired=2.
- Load extraction: memReadData=0x8081F27F.
  - LB off=0 -> 0x0000007F.
  - LB off=3 -> 0xFFFFFF80.
  - LBU off=2 -> 0x00000081.
  - LH off=2 -> 0xFFFF8081.
  - LHU off=0 -> 0x0000F27F.
  - LW off=0 -> 0x8081F27F.
- Misalign: LW with exAluResult=0x1002.
  - MISALIGN_TRAP=1 -> RegWrite=0, loadMisalign=1 for one cycle, instRetired unchanged.
  - MISALIGN_TRAP=0 -> WriteData=memReadData, RegWrite=1.
- Stall/flush: capture rd=3 value 0x11, then stall 3 cycles while inputs change -> outputs hold 0x11/3/RegWrite=1. Assert flush and stall together -> bubble (RegWrite=0, wbValid=0).
- Counter wrap: with CNT_WIDTH=4, retire 17 valid instructions -> instRetired=1.

Source files
------------

// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_stage
// MEM/WB pipeline stage of the 5-stage RV32I core. Latches the EX/MEM result
// and the raw data-memory word, extracts and sign/zero-extends load data,
// and drives the register-file write port. Misaligned loads are either
// trapped (write suppressed, loadMisalign pulsed) or silently realigned,
// selected by MISALIGN_TRAP. A wrapping counter tracks retired instructions.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   stall, flush        hold stage / insert bubble (rst > flush > stall)
//   exValid .. exAluResult  EX/MEM slot contents
//   memReadData         aligned data word for exAluResult[31:2]
//   WriteAddr/WriteData/RegWrite  register-file write port (registered)
//   wbValid             stage holds a retiring instruction
//   loadMisalign        one-cycle misaligned-load flag (held under stall)
//   instRetired         retired-instruction count, wraps modulo 2^CNT_WIDTH
// ---------------------------------------------------------------------------
module mem_wb_stage #(
    parameter int CNT_WIDTH     = 32,
    parameter bit MISALIGN_TRAP = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 exValid,
    input  logic                 exRegWrite,
    input  logic                 exMemToReg,
    input  logic [4:0]           exRdAddr,
    input  logic [2:0]           exFunct3,
    input  logic [31:0]          exAluResult,
    input  logic [31:0]          memReadData,
    output logic [4:0]           WriteAddr,
    output logic [31:0]          WriteData,
    output logic                 RegWrite,
    output logic                 wbValid,
    output logic                 loadMisalign,
    output logic [CNT_WIDTH-1:0] instRetired
);

    logic [1:0]           off_s;
    logic [1:0]           sel_off_s;
    logic                 is_load_s;
    logic                 mis_s;
    logic [7:0]           byte_s;
    logic [15:0]          half_s;
    logic [31:0]          load_data_s;
    logic [31:0]          wr_data_s;
    logic                 reg_write_s;
    logic                 valid_s;

    logic [4:0]           write_addr_r;
    logic [31:0]          write_data_r;
    logic                 reg_write_r;
    logic                 wb_valid_r;
    logic                 load_misalign_r;
    logic [CNT_WIDTH-1:0] inst_retired_r;

    // Misalignment detection and the byte offset actually used for extraction.
    // Only funct3[1:0] decides the access size here, so 011/111 (treated as
    // LW for data) are never flagged, while 110 is checked like a word.
    always_comb begin
        off_s     = exAluResult[1:0];
        is_load_s = exMemToReg & exValid;
        mis_s     = 1'b0;
        sel_off_s = off_s;
        case (exFunct3[1:0])
            2'b01: begin
                if (MISALIGN_TRAP) begin
                    mis_s     = is_load_s & off_s[0];
                    sel_off_s = off_s;
                end else begin
                    mis_s     = 1'b0;
                    sel_off_s = {off_s[1], 1'b0};
                end
            end
            2'b10: begin
                if (MISALIGN_TRAP) begin
                    mis_s     = is_load_s & (off_s != 2'b00);
                    sel_off_s = off_s;
                end else begin
                    mis_s     = 1'b0;
                    sel_off_s = 2'b00;
                end
            end
            default: begin
                mis_s     = 1'b0;
                sel_off_s = off_s;
            end
        endcase
    end

    // Load data extraction, extension and writeback selection.
    always_comb begin
        case (sel_off_s)
            2'b00:   byte_s = memReadData[7:0];
            2'b01:   byte_s = memReadData[15:8];
            2'b10:   byte_s = memReadData[23:16];
            2'b11:   byte_s = memReadData[31:24];
            default: byte_s = 8'h00;
        endcase
        if (sel_off_s[1]) begin
            half_s = memReadData[31:16];
        end else begin
            half_s = memReadData[15:0];
        end
        case (exFunct3)
            3'b000:  load_data_s = {{24{byte_s[7]}}, byte_s};
            3'b001:  load_data_s = {{16{half_s[15]}}, half_s};
            3'b100:  load_data_s = {24'h000000, byte_s};
            3'b101:  load_data_s = {16'h0000, half_s};
            default: load_data_s = memReadData;
        endcase
        if (exMemToReg) begin
            wr_data_s = load_data_s;
        end else begin
            wr_data_s = exAluResult;
        end
        reg_write_s = exValid & exRegWrite & (exRdAddr != 5'd0) & ~mis_s;
        valid_s     = exValid & ~mis_s;
    end

    // Stage registers: reset, flush bubble, stall hold, or capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            write_addr_r    <= 5'd0;
            write_data_r    <= 32'h0000_0000;
            reg_write_r     <= 1'b0;
            wb_valid_r      <= 1'b0;
            load_misalign_r <= 1'b0;
            inst_retired_r  <= {CNT_WIDTH{1'b0}};
        end else if (flush) begin
            write_addr_r    <= 5'd0;
            write_data_r    <= 32'h0000_0000;
            reg_write_r     <= 1'b0;
            wb_valid_r      <= 1'b0;
            load_misalign_r <= 1'b0;
            inst_retired_r  <= inst_retired_r;
        end else if (stall) begin
            write_addr_r    <= write_addr_r;
            write_data_r    <= write_data_r;
            reg_write_r     <= reg_write_r;
            wb_valid_r      <= wb_valid_r;
            load_misalign_r <= load_misalign_r;
            inst_retired_r  <= inst_retired_r;
        end else begin
            write_addr_r    <= exRdAddr;
            write_data_r    <= wr_data_s;
            reg_write_r     <= reg_write_s;
            wb_valid_r      <= valid_s;
            load_misalign_r <= mis_s;
            if (valid_s) begin
                inst_retired_r <= inst_retired_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                inst_retired_r <= inst_retired_r;
            end
        end
    end

    assign WriteAddr    = write_addr_r;
    assign WriteData    = write_data_r;
    assign RegWrite     = reg_write_r;
    assign wbValid      = wb_valid_r;
    assign loadMisalign = load_misalign_r;
    assign instRetired  = inst_retired_r;

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic        exValid, exRegWrite, exMemToReg;
    logic [4:0]  exRdAddr;
    logic [2:0]  exFunct3;
    logic [31:0] exAluResult, memReadData;

    // instance 0: trapping, 32-bit counter; instance 1: realigning, 4-bit counter
    logic [4:0]  t_addr, n_addr;
    logic [31:0] t_data, n_data;
    logic        t_rw, n_rw, t_v, n_v, t_lm, n_lm;
    logic [31:0] t_cnt;
    logic [3:0]  n_cnt;

    int checks = 0;
    int errors = 0;

    // model state, index 0 = trap instance, 1 = no-trap instance
    logic [4:0]  m_addr[2];
    logic [31:0] m_data[2];
    logic        m_rw[2], m_v[2], m_lm[2];
    logic [31:0] m_cnt[2];

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] exp;
    } load_vec_t;
    load_vec_t vecs[9];

    mem_wb_stage #(.CNT_WIDTH(32), .MISALIGN_TRAP(1'b1)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .exValid(exValid),
        .exRegWrite(exRegWrite), .exMemToReg(exMemToReg), .exRdAddr(exRdAddr),
        .exFunct3(exFunct3), .exAluResult(exAluResult), .memReadData(memReadData),
        .WriteAddr(t_addr), .WriteData(t_data), .RegWrite(t_rw), .wbValid(t_v),
        .loadMisalign(t_lm), .instRetired(t_cnt));

    mem_wb_stage #(.CNT_WIDTH(4), .MISALIGN_TRAP(1'b0)) dut_nt (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .exValid(exValid),
        .exRegWrite(exRegWrite), .exMemToReg(exMemToReg), .exRdAddr(exRdAddr),
        .exFunct3(exFunct3), .exAluResult(exAluResult), .memReadData(memReadData),
        .WriteAddr(n_addr), .WriteData(n_data), .RegWrite(n_rw), .wbValid(n_v),
        .loadMisalign(n_lm), .instRetired(n_cnt));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference load: access size from funct3[1:0] for alignment, from funct3 for data.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] mem,
                                             input logic [31:0] addr, input bit trap,
                                             input bit is_load, output bit mis);
        int off, align, width;
        logic [31:0] raw;
        off   = int'(addr % 32'd4);
        align = (f3[1:0] == 2'd1) ? 2 : ((f3[1:0] == 2'd2) ? 4 : 1);
        mis   = is_load && ((off % align) != 0);
        if (!trap) begin
            mis = 1'b0;
            off = off - (off % align);
        end
        if (f3 == 3'd0 || f3 == 3'd4) width = 1;
        else if (f3 == 3'd1 || f3 == 3'd5) width = 2;
        else width = 4;
        if (width == 1) begin
            raw = (mem >> (8 * off)) & 32'hFF;
            if (!f3[2] && raw >= 32'd128) raw = raw - 32'd256;
        end else if (width == 2) begin
            raw = (mem >> (16 * (off / 2))) & 32'hFFFF;
            if (!f3[2] && raw >= 32'd32768) raw = raw - 32'd65536;
        end else begin
            raw = mem;
        end
        return raw;
    endfunction

    task automatic model_edge();
        bit mis;
        logic [31:0] ld;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_addr[k] = 5'd0; m_data[k] = 32'd0; m_rw[k] = 1'b0;
                m_v[k] = 1'b0; m_lm[k] = 1'b0; m_cnt[k] = 32'd0;
            end else if (flush) begin
                m_addr[k] = 5'd0; m_data[k] = 32'd0; m_rw[k] = 1'b0;
                m_v[k] = 1'b0; m_lm[k] = 1'b0;
            end else if (!stall) begin
                ld = ref_load(exFunct3, memReadData, exAluResult, (k == 0),
                              exMemToReg && exValid, mis);
                m_addr[k] = exRdAddr;
                m_data[k] = exMemToReg ? ld : exAluResult;
                m_rw[k]   = exValid && exRegWrite && (exRdAddr != 5'd0) && !mis;
                m_v[k]    = exValid && !mis;
                m_lm[k]   = mis;
                if (exValid && !mis)
                    m_cnt[k] = (k == 0) ? m_cnt[k] + 32'd1 : (m_cnt[k] + 32'd1) % 32'd16;
            end
        end
    endtask

    task automatic compare_model();
        check("trap.WriteAddr", {27'd0, t_addr}, {27'd0, m_addr[0]});
        check("trap.WriteData", t_data, m_data[0]);
        check("trap.RegWrite", {31'd0, t_rw}, {31'd0, m_rw[0]});
        check("trap.wbValid", {31'd0, t_v}, {31'd0, m_v[0]});
        check("trap.loadMisalign", {31'd0, t_lm}, {31'd0, m_lm[0]});
        check("trap.instRetired", t_cnt, m_cnt[0]);
        check("nt.WriteAddr", {27'd0, n_addr}, {27'd0, m_addr[1]});
        check("nt.WriteData", n_data, m_data[1]);
        check("nt.RegWrite", {31'd0, n_rw}, {31'd0, m_rw[1]});
        check("nt.wbValid", {31'd0, n_v}, {31'd0, m_v[1]});
        check("nt.loadMisalign", {31'd0, n_lm}, {31'd0, m_lm[1]});
        check("nt.instRetired", {28'd0, n_cnt}, m_cnt[1]);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic set_instr(input logic v, input logic rw, input logic m2r, input logic [4:0] rd,
                             input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] mem);
        exValid = v; exRegWrite = rw; exMemToReg = m2r; exRdAddr = rd;
        exFunct3 = f3; exAluResult = alu; memReadData = mem;
    endtask

    initial begin
        vecs[0] = '{3'b000, 32'h0000_1000, 32'h0000_007F};
        vecs[1] = '{3'b000, 32'h0000_1003, 32'hFFFF_FF80};
        vecs[2] = '{3'b100, 32'h0000_1002, 32'h0000_0081};
        vecs[3] = '{3'b001, 32'h0000_1002, 32'hFFFF_8081};
        vecs[4] = '{3'b101, 32'h0000_1000, 32'h0000_F27F};
        vecs[5] = '{3'b010, 32'h0000_1000, 32'h8081_F27F};
        vecs[6] = '{3'b000, 32'h0000_1001, 32'hFFFF_FFF2};
        vecs[7] = '{3'b101, 32'h0000_1002, 32'h0000_8081};
        vecs[8] = '{3'b011, 32'h0000_1001, 32'h8081_F27F};

        // reset with a live instruction present
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        set_instr(1'b1, 1'b1, 1'b0, 5'd5, 3'b010, 32'h0000_0055, 32'h0);
        tick();
        tick();
        check("reset.RegWrite", {31'd0, t_rw}, 32'd0);
        check("reset.instRetired", t_cnt, 32'd0);
        rst = 1'b0;
        tick();
        check("post_reset.WriteAddr", {27'd0, t_addr}, 32'd5);
        check("post_reset.RegWrite", {31'd0, t_rw}, 32'd1);

        // ALU writeback, then the same to x0
        set_instr(1'b1, 1'b1, 1'b0, 5'd7, 3'b000, 32'hDEAD_BEEF, 32'h0);
        tick();
        check("alu.WriteData", t_data, 32'hDEAD_BEEF);
        check("alu.WriteAddr", {27'd0, t_addr}, 32'd7);
        check("alu.instRetired", t_cnt, 32'd2);
        exRdAddr = 5'd0;
        tick();
        check("alu_x0.RegWrite", {31'd0, t_rw}, 32'd0);
        check("alu_x0.instRetired", t_cnt, 32'd3);

        // load extraction table
        for (int i = 0; i < 9; i++) begin
            set_instr(1'b1, 1'b1, 1'b1, 5'(10 + i), vecs[i].f3, vecs[i].addr, 32'h8081_F27F);
            tick();
            check($sformatf("load%0d.trap.WriteData", i), t_data, vecs[i].exp);
            check($sformatf("load%0d.nt.WriteData", i), n_data, vecs[i].exp);
            check($sformatf("load%0d.RegWrite", i), {31'd0, t_rw}, 32'd1);
        end

        // misaligned LW: trap instance suppresses, no-trap writes the full word
        set_instr(1'b1, 1'b1, 1'b1, 5'd9, 3'b010, 32'h0000_1002, 32'h8081_F27F);
        tick();
        check("mis.trap.RegWrite", {31'd0, t_rw}, 32'd0);
        check("mis.trap.loadMisalign", {31'd0, t_lm}, 32'd1);
        check("mis.trap.instRetired", t_cnt, 32'd12);
        check("mis.nt.WriteData", n_data, 32'h8081_F27F);
        check("mis.nt.RegWrite", {31'd0, n_rw}, 32'd1);
        set_instr(1'b0, 1'b0, 1'b0, 5'd0, 3'b000, 32'h0, 32'h0);
        tick();
        check("mis.pulse_end", {31'd0, t_lm}, 32'd0);

        // misaligned LH held under stall
        set_instr(1'b1, 1'b1, 1'b1, 5'd4, 3'b001, 32'h0000_2003, 32'h1234_5678);
        tick();
        stall = 1'b1;
        set_instr(1'b1, 1'b1, 1'b0, 5'd6, 3'b000, 32'h0, 32'h0);
        tick();
        check("mis_stall.loadMisalign", {31'd0, t_lm}, 32'd1);
        stall = 1'b0;

        // stall holds a captured write, flush+stall yields a bubble
        set_instr(1'b1, 1'b1, 1'b0, 5'd3, 3'b000, 32'h0000_0011, 32'h0);
        tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_instr(1'b1, 1'b1, 1'b0, 5'(20 + i), 3'b000, 32'h100 + 32'(i), 32'h0);
            tick();
            check("stall.WriteData", t_data, 32'h0000_0011);
            check("stall.WriteAddr", {27'd0, t_addr}, 32'd3);
            check("stall.RegWrite", {31'd0, t_rw}, 32'd1);
        end
        flush = 1'b1;
        tick();
        check("flush.RegWrite", {31'd0, t_rw}, 32'd0);
        check("flush.wbValid", {31'd0, t_v}, 32'd0);
        flush = 1'b0; stall = 1'b0;

        // counter wrap on the 4-bit instance
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 17; i++) begin
            set_instr(1'b1, 1'(i % 2), 1'b0, 5'(i), 3'b000, 32'(i), 32'h0);
            tick();
        end
        check("wrap.nt.instRetired", {28'd0, n_cnt}, 32'd1);
        check("wrap.trap.instRetired", t_cnt, 32'd17);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst   = ($urandom_range(63) == 0);
            flush = ($urandom_range(7) == 0);
            stall = ($urandom_range(5) == 0);
            set_instr(1'($urandom_range(3) != 0), 1'($urandom), 1'($urandom),
                      ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom),
                      3'($urandom), $urandom, $urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
